// File: rtl/latched_shift_register_pkg.sv
// Shared types and sizing helpers for the latched serial-to-parallel capture register.
package shift_register_pkg;

  typedef enum logic {
    SHIFT_MSB_IN = 1'b0,
    SHIFT_LSB_IN = 1'b1
  } shift_order_e;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/latched_shift_register_if.sv
// Capture-register bus: sampled printhead inputs in, latched frame and status out.
interface latched_shift_register_if #(
  parameter int DEPTH = 64,
  parameter int LANES = 1
);
  import shift_register_pkg::*;

  localparam int CW = count_width(DEPTH);

  logic [LANES-1:0] data_in;
  logic             enable;
  logic             lsb_first;
  logic             latch;
  logic             clear;
  logic [DEPTH-1:0] data_out;
  logic             latch_valid;
  logic             short_frame;
  logic             overrun;
  logic [CW-1:0]    bit_count;
  logic             full;

  modport master (
    output data_in, enable, lsb_first, latch, clear,
    input  data_out, latch_valid, short_frame, overrun, bit_count, full
  );

  modport slave (
    input  data_in, enable, lsb_first, latch, clear,
    output data_out, latch_valid, short_frame, overrun, bit_count, full
  );

endinterface

// File: rtl/latched_shift_register_counter.sv
// Saturating frame bit counter with full decode and sticky overrun flag.
module frame_bit_counter
  import shift_register_pkg::*;
#(
  parameter int MAX  = 64,
  parameter int STEP = 1,
  localparam int CW  = count_width(MAX)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc_i,
  input  logic          restart_i,
  input  logic          clear_i,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          overrun_o
);

  localparam logic [CW-1:0] MAX_C  = CW'(MAX);
  localparam logic [CW-1:0] STEP_C = CW'(STEP);

  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a);
    logic [CW:0] sum;
    sum = {1'b0, a} + {1'b0, STEP_C};
    return (sum > {1'b0, MAX_C}) ? MAX_C : sum[CW-1:0];
  endfunction

  assign full_o    = (count_q == MAX_C);
  assign count_o   = count_q;
  assign overrun_o = overrun_q;

  // A restart that coincides with an increment opens the next frame already holding STEP bits.
  always_comb begin
    count_d   = count_q;
    overrun_d = overrun_q;
    if (clear_i) begin
      count_d   = '0;
      overrun_d = 1'b0;
    end else if (restart_i) begin
      count_d   = inc_i ? STEP_C : '0;
      overrun_d = 1'b0;
    end else if (inc_i) begin
      if (full_o) overrun_d = 1'b1;
      else        count_d   = sat_add(count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: rtl/latched_shift_register.sv
// Multi-lane serial-to-parallel shifter with a latch-strobed holding register.
module latched_shift_register
  import shift_register_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int LANES = 1
) (
  input logic                        clk,
  input logic                        reset,
  latched_shift_register_if.slave    bus
);

  localparam int CW = count_width(DEPTH);

  if ((DEPTH % LANES) != 0 || DEPTH < 2 * LANES) begin : g_bad_params
    $error("latched_shift_register: DEPTH must be a multiple of LANES and >= 2*LANES");
  end

  logic [DEPTH-1:0] sreg_q, sreg_d;
  logic [DEPTH-1:0] data_out_q;
  logic             latch_valid_q;
  logic             short_frame_q;
  logic [CW-1:0]    bit_count;
  logic             full;
  logic             overrun;
  logic             latch_go;

  assign latch_go = bus.latch & ~bus.clear;

  frame_bit_counter #(.MAX(DEPTH), .STEP(LANES)) u_counter (
    .clk       (clk),
    .reset     (reset),
    .inc_i     (bus.enable),
    .restart_i (bus.latch),
    .clear_i   (bus.clear),
    .count_o   (bit_count),
    .full_o    (full),
    .overrun_o (overrun)
  );

  always_comb begin
    sreg_d = sreg_q;
    if (bus.clear) begin
      sreg_d = '0;
    end else if (bus.enable) begin
      if (shift_order_e'(bus.lsb_first) == SHIFT_LSB_IN)
        sreg_d = {bus.data_in, sreg_q[DEPTH-1:LANES]};
      else
        sreg_d = {sreg_q[DEPTH-LANES-1:0], bus.data_in};
    end
  end

  // The holding register samples the pre-shift frame; the shifter itself is never flushed by a latch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sreg_q        <= '0;
      data_out_q    <= '0;
      latch_valid_q <= 1'b0;
      short_frame_q <= 1'b0;
    end else begin
      sreg_q        <= sreg_d;
      latch_valid_q <= latch_go;
      short_frame_q <= latch_go & ~full;
      if (latch_go) data_out_q <= sreg_q;
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.latch_valid = latch_valid_q;
  assign bus.short_frame = short_frame_q;
  assign bus.overrun     = overrun;
  assign bus.bit_count   = bit_count;
  assign bus.full        = full;

endmodule
